// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared types and constants for the RTC time-set front end:
//                FSM state encoding, BCD limits, edit-field codes and a
//                seed-validity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;
    localparam logic [DIGIT_W-1:0] HR_MAX_M  = 4'd2;
    localparam logic [DIGIT_W-1:0] HR_MAX_L  = 4'd3;
    localparam logic [DIGIT_W-1:0] MIN_MAX_M = 4'd5;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EDIT_HR  = 2'd1,
        ST_EDIT_MIN = 2'd2,
        ST_LOAD     = 2'd3
    } state_t;

    // True when HH:MM is a legal 24-hour BCD time.
    function automatic logic bcd_hhmm_valid(
        input logic [DIGIT_W-1:0] hr_m,
        input logic [DIGIT_W-1:0] hr_l,
        input logic [DIGIT_W-1:0] min_m,
        input logic [DIGIT_W-1:0] min_l
    );
        logic ok;
        ok = (hr_l <= BCD_MAX) && (min_l <= BCD_MAX) &&
             (hr_m <= HR_MAX_M) && (min_m <= MIN_MAX_M);
        if ((hr_m == HR_MAX_M) && (hr_l > HR_MAX_L))
            ok = 1'b0;
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_btn_debounce
//  Description : Raw push-button conditioner: 2-flop synchroniser, counting
//                debouncer and rising-edge detector giving a 1-cycle press
//                pulse one cycle after the debounced level rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_btn_debounce #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int              CNT_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Flip the level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync1 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered rising-edge pulse; releases produce nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/rtc_time_setter.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_time_setter
//  Description : Time-set front end for the HH:MM:SS clock. Two debounced
//                buttons walk an hours/minutes edit seeded from the live
//                time, then the new HH:MM is offered on a valid/ready bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_setter
    import rtc_pkg::*;
#(
    parameter int DB_CYCLES      = 20000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode_raw,
    input  logic               btn_inc_raw,
    input  logic [DIGIT_W-1:0] cur_hr_m,
    input  logic [DIGIT_W-1:0] cur_hr_l,
    input  logic [DIGIT_W-1:0] cur_min_m,
    input  logic [DIGIT_W-1:0] cur_min_l,
    output logic [DIGIT_W-1:0] edit_hr_m,
    output logic [DIGIT_W-1:0] edit_hr_l,
    output logic [DIGIT_W-1:0] edit_min_m,
    output logic [DIGIT_W-1:0] edit_min_l,
    output logic               editing,
    output logic [1:0]         edit_field,
    output logic               load_valid,
    input  logic               load_ready
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic w_mode_press;
    logic w_inc_press;

    state_t             r_state, w_state_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [DIGIT_W-1:0] r_hr_m, r_hr_l, r_min_m, r_min_l;
    logic [DIGIT_W-1:0] w_hr_m_nxt, w_hr_l_nxt, w_min_m_nxt, w_min_l_nxt;
    logic [1:0]         w_field_nxt;
    logic               r_editing;
    logic [1:0]         r_field;
    logic               r_load_valid;

    rtc_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk       (clk),
        .reset     (reset),
        .i_btn_raw (btn_mode_raw),
        .o_press   (w_mode_press)
    );

    rtc_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk       (clk),
        .reset     (reset),
        .i_btn_raw (btn_inc_raw),
        .o_press   (w_inc_press)
    );

    // Next state, digit edits and timeout count; mode press always beats inc.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_hr_m_nxt  = r_hr_m;
        w_hr_l_nxt  = r_hr_l;
        w_min_m_nxt = r_min_m;
        w_min_l_nxt = r_min_l;
        case (r_state)
            ST_IDLE: begin
                w_tmo_nxt = '0;
                if (w_mode_press) begin
                    w_state_nxt = ST_EDIT_HR;
                    if (bcd_hhmm_valid(cur_hr_m, cur_hr_l, cur_min_m, cur_min_l)) begin
                        w_hr_m_nxt  = cur_hr_m;
                        w_hr_l_nxt  = cur_hr_l;
                        w_min_m_nxt = cur_min_m;
                        w_min_l_nxt = cur_min_l;
                    end else begin
                        w_hr_m_nxt  = '0;
                        w_hr_l_nxt  = '0;
                        w_min_m_nxt = '0;
                        w_min_l_nxt = '0;
                    end
                end
            end
            ST_EDIT_HR: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_EDIT_MIN;
                    w_tmo_nxt   = '0;
                end else if (w_inc_press) begin
                    w_tmo_nxt = '0;
                    if ((r_hr_m == HR_MAX_M) && (r_hr_l == HR_MAX_L)) begin
                        w_hr_m_nxt = '0;
                        w_hr_l_nxt = '0;
                    end else if (r_hr_l == BCD_MAX) begin
                        w_hr_l_nxt = '0;
                        w_hr_m_nxt = r_hr_m + 4'd1;
                    end else begin
                        w_hr_l_nxt = r_hr_l + 4'd1;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_EDIT_MIN: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_LOAD;
                    w_tmo_nxt   = '0;
                end else if (w_inc_press) begin
                    w_tmo_nxt = '0;
                    if ((r_min_m == MIN_MAX_M) && (r_min_l == BCD_MAX)) begin
                        w_min_m_nxt = '0;
                        w_min_l_nxt = '0;
                    end else if (r_min_l == BCD_MAX) begin
                        w_min_l_nxt = '0;
                        w_min_m_nxt = r_min_m + 4'd1;
                    end else begin
                        w_min_l_nxt = r_min_l + 4'd1;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_LOAD: begin
                w_tmo_nxt = '0;
                if (r_load_valid && load_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // Field code for the blink logic, derived from the upcoming state.
    always_comb begin
        w_field_nxt = FIELD_NONE;
        case (w_state_nxt)
            ST_EDIT_HR:  w_field_nxt = FIELD_HOURS;
            ST_EDIT_MIN: w_field_nxt = FIELD_MINUTES;
            default:     w_field_nxt = FIELD_NONE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Working digits and idle timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo   <= '0;
            r_hr_m  <= '0;
            r_hr_l  <= '0;
            r_min_m <= '0;
            r_min_l <= '0;
        end else begin
            r_tmo   <= w_tmo_nxt;
            r_hr_m  <= w_hr_m_nxt;
            r_hr_l  <= w_hr_l_nxt;
            r_min_m <= w_min_m_nxt;
            r_min_l <= w_min_l_nxt;
        end
    end

    // Status outputs registered alongside the state so they move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_editing    <= 1'b0;
            r_field      <= FIELD_NONE;
            r_load_valid <= 1'b0;
        end else begin
            r_editing    <= (w_state_nxt != ST_IDLE);
            r_field      <= w_field_nxt;
            r_load_valid <= (w_state_nxt == ST_LOAD);
        end
    end

    assign edit_hr_m  = r_hr_m;
    assign edit_hr_l  = r_hr_l;
    assign edit_min_m = r_min_m;
    assign edit_min_l = r_min_l;
    assign editing    = r_editing;
    assign edit_field = r_field;
    assign load_valid = r_load_valid;

endmodule
`default_nettype wire
